a2d_resp: RTL and testbench

A2D_RESP -- requirements
Module: a2d_resp

---
 rtl/a2d_resp.sv | 135 +++++++++++++
 tb/tb_a2d_resp.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/a2d_resp.sv
// SPI responder (mode 0) for an 8-channel A2D front end: returns the channel
// addressed by the previous complete command frame, MSB first on MISO.
module a2d_resp #(
    parameter logic [2:0] DEF_CH = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        SS_n,
    input  logic [95:0] chan_vals,
    output logic        MISO,
    output logic [15:0] cmd,
    output logic        cmd_vld,
    output logic        frame_err
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state_q, state_d;
    // [0] first sync flop, [1] second sync flop, [2] history flop
    logic [2:0]  sclk_sync_q, sclk_sync_d;
    logic [2:0]  mosi_sync_q, mosi_sync_d;
    logic [2:0]  ss_sync_q, ss_sync_d;
    logic [1:0]  sync_vld_q, sync_vld_d;
    logic        armed_q, armed_d;
    logic [15:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  sel_ch_q, sel_ch_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_vld_q, cmd_vld_d;
    logic        frame_err_q, frame_err_d;

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
    assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];

    always_comb begin
        state_d     = state_q;
        sclk_sync_d = {sclk_sync_q[1:0], SCLK};
        mosi_sync_d = {mosi_sync_q[1:0], MOSI};
        ss_sync_d   = {ss_sync_q[1:0], SS_n};
        sync_vld_d  = {sync_vld_q[0], 1'b1};
        armed_d     = armed_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        sel_ch_d    = sel_ch_q;
        cmd_d       = cmd_q;
        cmd_vld_d   = 1'b0;
        frame_err_d = 1'b0;

        // A select that is already low when reset releases must go high
        // (as seen through a flushed synchronizer) before a fall counts.
        if (sync_vld_q[1] && ss_sync_q[1]) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ss_fall && armed_q) begin
                    state_d   = SHIFT;
                    tx_d      = {4'b0000, chan_vals[32'(sel_ch_q) * 12 +: 12]};
                    bit_cnt_d = 5'd0;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    if (bit_cnt_q == 5'd16) begin
                        cmd_d     = rx_q;
                        sel_ch_d  = rx_q[13:11];
                        cmd_vld_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    if (sclk_fall) begin
                        tx_d = {tx_q[14:0], 1'b0};
                    end
                    // MOSI history sample lines up with the pre-edge SCLK sample
                    if (sclk_rise) begin
                        rx_d = {rx_q[14:0], mosi_sync_q[2]};
                        if (bit_cnt_q != 5'd17) begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_sync_q <= 3'b000;
            mosi_sync_q <= 3'b000;
            ss_sync_q   <= 3'b111;
            sync_vld_q  <= 2'b00;
            armed_q     <= 1'b0;
            tx_q        <= 16'h0000;
            rx_q        <= 16'h0000;
            bit_cnt_q   <= 5'd0;
            sel_ch_q    <= DEF_CH;
            cmd_q       <= 16'h0000;
            cmd_vld_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            sync_vld_q  <= sync_vld_d;
            armed_q     <= armed_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            bit_cnt_q   <= bit_cnt_d;
            sel_ch_q    <= sel_ch_d;
            cmd_q       <= cmd_d;
            cmd_vld_q   <= cmd_vld_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign MISO      = (state_q == SHIFT) & tx_q[15];
    assign cmd       = cmd_q;
    assign cmd_vld   = cmd_vld_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_a2d_resp.sv
// Scoreboard bench for a2d_resp: an SPI initiator drives frames, a channel
// model predicts each frame's outcome, and monitors check what the DUT returns.
module tb_a2d_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        SCLK;
    logic        MOSI;
    logic        SS_n;
    logic [95:0] chan_vals;
    logic        MISO;
    logic [15:0] cmd;
    logic        cmd_vld;
    logic        frame_err;

    always #5 clk = ~clk;

    a2d_resp #(.DEF_CH(3'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .SS_n      (SS_n),
        .chan_vals (chan_vals),
        .MISO      (MISO),
        .cmd       (cmd),
        .cmd_vld   (cmd_vld),
        .frame_err (frame_err)
    );

    typedef struct {
        bit          is_err;
        logic [15:0] cmd;
        logic [15:0] miso;
        int          nbits;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [2:0]  m_sel;
    logic [15:0] m_cmd;

    logic [15:0] mon_word;
    int          mon_cnt;
    logic        mon_extra;
    exp_t        mon_e;
    logic [15:0] mon_mask;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    function automatic logic [11:0] ch(input logic [2:0] k);
        return chan_vals[int'(k) * 12 +: 12];
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // MISO as the initiator sees it: sampled on each SCLK rising edge.
    always @(negedge SS_n) begin
        mon_word  = 16'h0000;
        mon_cnt   = 0;
        mon_extra = 1'b0;
    end

    always @(posedge SCLK) begin
        if (SS_n == 1'b0) begin
            if (mon_cnt < 16) mon_word[15 - mon_cnt] = MISO;
            else mon_extra = mon_extra | MISO;
            mon_cnt++;
        end
    end

    always @(negedge clk) begin
        if (cmd_vld === 1'b1 || frame_err === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {30'b0, cmd_vld, frame_err}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", {30'b0, cmd_vld, frame_err}, mon_e.is_err ? 32'd1 : 32'd2);
                check("cmd", {16'b0, cmd}, {16'b0, mon_e.cmd});
                mon_mask = 16'h0000;
                for (int i = 0; i < 16 && i < mon_e.nbits; i++) mon_mask[15 - i] = 1'b1;
                check("miso_stream", {16'b0, mon_word & mon_mask}, {16'b0, mon_e.miso & mon_mask});
                if (mon_e.nbits > 16) check("miso_tail", {31'b0, mon_extra}, 32'd0);
            end
        end
    end

    task automatic spi_frame(input int nbits, input logic [15:0] word,
                             input bit chg, input logic [95:0] new_vals);
        exp_t        e;
        logic [15:0] sh;
        e.miso  = {4'b0000, ch(m_sel)};
        e.nbits = nbits;
        if (nbits == 16) begin
            e.is_err = 1'b0;
            m_cmd    = word;
            m_sel    = word[13:11];
        end else begin
            e.is_err = 1'b1;
        end
        e.cmd = m_cmd;
        exp_q.push_back(e);

        sh   = word;
        SS_n = 1'b0;
        MOSI = sh[15];
        wait_clk(16);
        for (int i = 0; i < nbits; i++) begin
            MOSI = sh[15];
            sh   = sh << 1;
            wait_clk(16);
            SCLK = 1'b1;
            if (chg && i == 3) chan_vals = new_vals;
            wait_clk(16);
            SCLK = 1'b0;
        end
        wait_clk(16);
        SS_n = 1'b1;
        wait_clk(24);
        check("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] nv;
        int          nb;
        rst       = 1'b1;
        SS_n      = 1'b0;
        SCLK      = 1'b0;
        MOSI      = 1'b0;
        chan_vals = '0;
        chan_vals[11:0]  = 12'hABC;
        chan_vals[47:36] = 12'h123;
        m_sel = 3'd0;
        m_cmd = 16'h0000;
        wait_clk(3);
        check("rst_miso", {31'b0, MISO}, 32'd0);
        check("rst_cmd", {16'b0, cmd}, 32'd0);
        check("rst_cmd_vld", {31'b0, cmd_vld}, 32'd0);
        check("rst_frame_err", {31'b0, frame_err}, 32'd0);

        // Select already low at reset release: clocks must be ignored.
        rst = 1'b0;
        wait_clk(10);
        for (int i = 0; i < 16; i++) begin
            wait_clk(16); SCLK = 1'b1; wait_clk(16); SCLK = 1'b0;
        end
        wait_clk(16);
        SS_n = 1'b1;
        wait_clk(24);
        check("no_frame_low_at_release", {16'b0, cmd}, 32'd0);

        spi_frame(16, 16'h1800, 1'b0, '0);   // returns ch0 = ABC, selects ch3
        spi_frame(16, 16'h0000, 1'b0, '0);   // returns ch3 = 123, selects ch0
        spi_frame(16, 16'h1800, 1'b0, '0);   // returns ch0, selects ch3
        spi_frame(9,  16'h0000, 1'b0, '0);   // short frame
        spi_frame(16, 16'h1800, 1'b0, '0);   // still ch3
        spi_frame(18, 16'h0000, 1'b0, '0);   // overlong frame
        nv = chan_vals;
        nv[47:36] = 12'hFFF;
        spi_frame(16, 16'h1800, 1'b1, nv);   // mid-frame change must not show
        spi_frame(16, 16'h0000, 1'b0, '0);   // now returns FFF

        // Reset in the middle of a frame: no event, fresh fall required.
        SS_n = 1'b0;
        wait_clk(16);
        for (int i = 0; i < 5; i++) begin
            wait_clk(16); SCLK = 1'b1; wait_clk(16); SCLK = 1'b0;
        end
        rst = 1'b1;
        wait_clk(2);
        rst   = 1'b0;
        m_cmd = 16'h0000;
        m_sel = 3'd0;
        for (int i = 0; i < 11; i++) begin
            wait_clk(16); SCLK = 1'b1; wait_clk(16); SCLK = 1'b0;
        end
        wait_clk(16);
        SS_n = 1'b1;
        wait_clk(24);
        check("mid_rst_cmd", {16'b0, cmd}, 32'd0);
        check("mid_rst_miso", {31'b0, MISO}, 32'd0);
        spi_frame(16, 16'h2800, 1'b0, '0);   // default channel again

        for (int k = 0; k < 50; k++) begin
            nb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 20)) : 16;
            nv = {$urandom, $urandom, $urandom};
            spi_frame(nb, 16'($urandom), ($urandom_range(0, 3) == 0), nv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
